// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX datapaths.
// Holds the transmit state encoding, line levels and parity selection.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Turns the XOR-reduction of a payload into the frame parity bit.
   function automatic logic parity_bit(
      input logic ones_odd,
      input logic typ
   );
      return (typ == PAR_ODD) ? ~ones_odd : ones_odd;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART transmitter.
// ser_bit is the data bit that goes on the line at the coming edge.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  ser_bit,
   output logic                  ser_done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] sr_next;
   logic [CW-1:0]         cnt;

   assign sr_next = sr >> 1;

   // Bit 0 goes out from START; each shift exposes the following bit.
   assign ser_bit  = shift ? sr_next[0] : sr[0];
   assign ser_done = (cnt == LAST);

   // Load on accept, then shift once per data bit until the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= data;
         cnt <= '0;
      end else if (shift) begin
         sr  <= sr_next;
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one frame per request, one bit per CLK cycle.
// Start bit, LSB-first data, optional parity, one stop bit.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  READY,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;

   logic accept;
   logic shift;
   logic ser_bit;
   logic ser_done;
   logic par_bit;

   // A new frame may start from idle or overlap the stop bit.
   assign READY  = (state == IDLE) || (state == STOP);
   assign accept = DATA_VALID && READY;
   assign shift  = (state == DATA) && !ser_done;

   assign par_bit = parity_bit(^data_q, par_typ_q);

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk      (CLK),
      .rst      (RST),
      .load     (accept),
      .shift    (shift),
      .data     (P_DATA),
      .ser_bit  (ser_bit),
      .ser_done (ser_done)
   );

   // Hold the request fields for the whole frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (accept) begin
         data_q    <= P_DATA;
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
      end
   end

   // Frame FSM; TX_OUT and BUSY are registered with the next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         TX_OUT <= LINE_IDLE;
         BUSY   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state  <= START;
                  TX_OUT <= START_BIT;
                  BUSY   <= 1'b1;
               end else begin
                  TX_OUT <= LINE_IDLE;
                  BUSY   <= 1'b0;
               end
            end
            START: begin
               state  <= DATA;
               TX_OUT <= ser_bit;
               BUSY   <= 1'b1;
            end
            DATA: begin
               BUSY <= 1'b1;
               if (!ser_done) begin
                  TX_OUT <= ser_bit;
               end else if (par_en_q) begin
                  state  <= PARITY;
                  TX_OUT <= par_bit;
               end else begin
                  state  <= STOP;
                  TX_OUT <= STOP_BIT;
               end
            end
            PARITY: begin
               state  <= STOP;
               TX_OUT <= STOP_BIT;
               BUSY   <= 1'b1;
            end
            STOP: begin
               if (accept) begin
                  state  <= START;
                  TX_OUT <= START_BIT;
                  BUSY   <= 1'b1;
               end else begin
                  state  <= IDLE;
                  TX_OUT <= LINE_IDLE;
                  BUSY   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= LINE_IDLE;
               BUSY   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames plus random traffic.
// Expected line bits come from a frame-composition model.
module tb_uart_tx_frame;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       READY;
   logic       TX_OUT;
   logic       BUSY;

   int n_assert = 0;
   int n_fail   = 0;

   uart_tx_frame #(
      .DATA_WIDTH (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .READY      (READY),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, BUSY, 1'b0);
      chk({tag, "_ready"}, READY, 1'b1);
   endtask

   // Present a request in this cycle and let it be accepted.
   task automatic request(input logic [7:0] d, input logic en, input logic typ);
      P_DATA     = d;
      PAR_EN     = en;
      PAR_TYP    = typ;
      DATA_VALID = 1'b1;
      chk("req_ready", READY, 1'b1);
      tick();
      DATA_VALID = 1'b0;
   endtask

   // Walk an accepted frame bit by bit against the model.
   // pulse_k: cycle of a stray request; abort_k: cycle that asserts RST.
   task automatic check_frame(
      input logic [7:0] d,
      input logic       en,
      input logic       typ,
      input int         pulse_k,
      input int         abort_k,
      input logic       chain,
      input logic [7:0] cd,
      input logic       cen,
      input logic       ctyp
   );
      logic q[$];
      int   last;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (en) q.push_back((($countones(d) % 2) == 1) ^ typ);
      q.push_back(1'b1);
      last = q.size() - 1;
      for (int k = 0; k <= last; k++) begin
         chk($sformatf("tx_%02h_bit%0d", d, k), TX_OUT, q[k]);
         chk($sformatf("busy_%02h_bit%0d", d, k), BUSY, 1'b1);
         chk($sformatf("ready_%02h_bit%0d", d, k), READY, k == last);
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
         DATA_VALID = 1'b0;
         if (k == abort_k) begin
            RST        = 1'b1;
            DATA_VALID = 1'b1;
            tick();
            RST        = 1'b0;
            DATA_VALID = 1'b0;
            return;
         end
         if (k == last && chain) begin
            P_DATA     = cd;
            PAR_EN     = cen;
            PAR_TYP    = ctyp;
            DATA_VALID = 1'b1;
         end else if (k == pulse_k) begin
            P_DATA     = 8'h55;
            DATA_VALID = 1'b1;
         end
         tick();
      end
      DATA_VALID = 1'b0;
   endtask

   initial begin
      logic [7:0] d, nd;
      logic       en, typ, nen, ntyp, ch;
      int         gap;

      RST        = 1'b1;
      DATA_VALID = 1'b0;
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      RST = 1'b0;
      tick();
      chk_idle("post_reset");

      request(8'hA5, 1'b1, 1'b0);
      check_frame(8'hA5, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_a5");

      request(8'h01, 1'b1, 1'b1);
      check_frame(8'h01, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_01_odd");

      request(8'h01, 1'b1, 1'b0);
      check_frame(8'h01, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_01_even");

      request(8'hFF, 1'b0, 1'b0);
      check_frame(8'hFF, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_ff");

      request(8'h3C, 1'b0, 1'b0);
      check_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b1, 8'hC3, 1'b0, 1'b0);
      check_frame(8'hC3, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_b2b");

      request(8'h0F, 1'b1, 1'b1);
      check_frame(8'h0F, 1'b1, 1'b1, 3, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_drop");
      tick();
      chk_idle("drop_stays_idle");

      request(8'hAA, 1'b1, 1'b0);
      check_frame(8'hAA, 1'b1, 1'b0, -1, 4, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("mid_reset");
      request(8'h12, 1'b1, 1'b1);
      check_frame(8'h12, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_idle("after_12");

      d   = 8'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      ch  = 1'b0;
      for (int n = 0; n < 24; n++) begin
         if (!ch) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            request(d, en, typ);
         end
         nd   = 8'($urandom);
         nen  = 1'($urandom);
         ntyp = 1'($urandom);
         ch   = (n < 23) ? 1'($urandom) : 1'b0;
         check_frame(d, en, typ, -1, -1, ch, nd, nen, ntyp);
         if (!ch) chk_idle($sformatf("rand_idle_%0d", n));
         d   = nd;
         en  = nen;
         typ = ntyp;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
